// File: rtl/ard_frame_assembler_if.sv
// Byte/frame bus between the UART receiver, the frame assembler and the Hamming decoder.
//   byte_in/byte_valid   : received byte and its one-cycle strobe (driven by master)
//   frame/frame_valid    : last completed frame and its one-cycle update pulse (driven by slave)
interface ard_frame_assembler_if #(
    parameter int unsigned FRAME_BYTES = 10
);
    logic [7:0]               byte_in;
    logic                     byte_valid;
    logic [8*FRAME_BYTES-1:0] frame;
    logic                     frame_valid;

    modport master (
        output byte_in,
        output byte_valid,
        input  frame,
        input  frame_valid
    );

    modport slave (
        input  byte_in,
        input  byte_valid,
        output frame,
        output frame_valid
    );
endinterface

// File: rtl/ard_frame_assembler.sv
// Collects FRAME_BYTES UART bytes into one frame (optionally bit-reversed) and
// presents it with a one-cycle strobe, holding it until the next completion.
// Optional feature macro: ARD_FRAME_TIMEOUT_EN enables the inter-byte timeout
// that discards partial frames and drives err_timeout/err_count.
// Ports:
//   clk         : clock, rising edge
//   reset       : asynchronous active-low reset
//   clear       : synchronous abort of any partial frame
//   bus         : slave side of byte_in/byte_valid in, frame/frame_valid out
//   busy        : a partial frame is held
//   err_timeout : one-cycle pulse when a partial frame is dropped by timeout
//   err_count   : saturating timeout count
module ard_frame_assembler #(
    parameter int unsigned FRAME_BYTES   = 10,
    parameter int unsigned CLKFRQ        = 100000000,
    parameter int unsigned BAUDRATE      = 9600,
    parameter int unsigned TIMEOUT_BYTES = 2,
    parameter bit          REVERSE       = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    ard_frame_assembler_if.slave  bus,
    output logic                  busy,
    output logic                  err_timeout,
    output logic [7:0]            err_count
);

    localparam int unsigned     FRAME_W        = 8 * FRAME_BYTES;
    localparam int unsigned     IDX_W          = $clog2(FRAME_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX      = IDX_W'(FRAME_BYTES - 1);
    localparam longint unsigned TIMEOUT_CYCLES =
        64'(TIMEOUT_BYTES) * 64'd10 * 64'(CLKFRQ) / 64'(BAUDRATE);

    // Elaboration-time parameter sanity checks
    if (FRAME_BYTES < 2 || FRAME_BYTES > 16) begin : g_bad_frame_bytes
        $error("ard_frame_assembler: FRAME_BYTES must be in 2..16");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("ard_frame_assembler: TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [FRAME_W-1:0]   raw_q, raw_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic                 fv_q, fv_d;
    logic                 busy_q, busy_d;

`ifdef ARD_FRAME_TIMEOUT_EN
    localparam int unsigned      TCNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic              et_q, et_d;
    logic [7:0]        ec_q, ec_d;
`endif

    // Bit-reverse the whole frame for the decoder's bit ordering
    function automatic logic [FRAME_W-1:0] bit_rev(input logic [FRAME_W-1:0] v);
        logic [FRAME_W-1:0] r;
        for (int i = 0; i < int'(FRAME_W); i++) begin
            r[i] = v[int'(FRAME_W) - 1 - i];
        end
        return r;
    endfunction

    // Next-state and output logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        raw_d   = raw_q;
        frame_d = frame_q;
        fv_d    = 1'b0;
`ifdef ARD_FRAME_TIMEOUT_EN
        tcnt_d  = '0;
        et_d    = 1'b0;
        ec_d    = ec_q;
`endif
        if (clear) begin
            state_d = IDLE;
            idx_d   = '0;
        end else begin
            // idx_q is 0 in IDLE, so one store path serves both states
            if (bus.byte_valid) begin
                for (int k = 0; k < int'(FRAME_BYTES); k++) begin
                    if (idx_q == IDX_W'(k)) begin
                        raw_d[8*k +: 8] = bus.byte_in;
                    end
                end
            end
            unique case (state_q)
                IDLE: begin
                    if (bus.byte_valid) begin
                        state_d = COLLECT;
                        idx_d   = IDX_W'(1);
                    end
                end
                COLLECT: begin
                    if (bus.byte_valid) begin
                        if (idx_q == LAST_IDX) begin
                            frame_d = REVERSE ? bit_rev(raw_d) : raw_d;
                            fv_d    = 1'b1;
                            state_d = IDLE;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
`ifdef ARD_FRAME_TIMEOUT_EN
                    else if (tcnt_q == TCNT_LAST) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        et_d    = 1'b1;
                        if (ec_q != 8'hFF) begin
                            ec_d = ec_q + 8'd1;
                        end
                    end else begin
                        tcnt_d = tcnt_q + TCNT_W'(1);
                    end
`endif
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            endcase
        end
        busy_d = (state_d == COLLECT);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            raw_q   <= '0;
            frame_q <= '0;
            fv_q    <= 1'b0;
            busy_q  <= 1'b0;
`ifdef ARD_FRAME_TIMEOUT_EN
            tcnt_q  <= '0;
            et_q    <= 1'b0;
            ec_q    <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            raw_q   <= raw_d;
            frame_q <= frame_d;
            fv_q    <= fv_d;
            busy_q  <= busy_d;
`ifdef ARD_FRAME_TIMEOUT_EN
            tcnt_q  <= tcnt_d;
            et_q    <= et_d;
            ec_q    <= ec_d;
`endif
        end
    end

    assign bus.frame       = frame_q;
    assign bus.frame_valid = fv_q;
    assign busy            = busy_q;
`ifdef ARD_FRAME_TIMEOUT_EN
    assign err_timeout     = et_q;
    assign err_count       = ec_q;
`else
    assign err_timeout     = 1'b0;
    assign err_count       = 8'd0;
`endif

endmodule

// File: doc/ard_frame_assembler.md
# ard_frame_assembler

Parametrised byte-to-frame assembler between the UART receiver and the Hamming decoder on the Arduino-to-elevator-controller link. It collects `FRAME_BYTES` received bytes into one wide frame and optionally bit-reverses the frame for the decoder. It then presents the frame with a one-cycle strobe and holds it stable until the next complete frame. An inter-byte timeout discards partial frames so that the link resynchronises after a dropped byte. Errors are reported as a pulse and as a saturating count.

## Interface
- `FRAME_BYTES`, 10: bytes per frame, legal range 2..16.
- `CLKFRQ`, 100000000: clock frequency in Hz.
- `BAUDRATE`, 9600: UART baud rate.
- `TIMEOUT_BYTES`, 2: inter-byte timeout in byte times. `TIMEOUT_CYCLES = TIMEOUT_BYTES*10*CLKFRQ/BAUDRATE`, using integer arithmetic.
- `REVERSE`, 1: when 1, `frame[i] = raw[8*FRAME_BYTES-1-i]`; when 0, `frame = raw`.

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `clear`, in, 1: synchronous abort; drops any partial frame and returns to IDLE.
- `byte_in`, in, 8: received byte; qualified by `byte_valid`.
- `byte_valid`, in, 1: one-cycle strobe from the UART receiver.
- `frame`, out, 8*FRAME_BYTES: last completed frame.
- `frame_valid`, out, 1: one-cycle pulse when `frame` updates.
- `busy`, out, 1: high while a partial frame is held (state COLLECT).
- `err_timeout`, out, 1: one-cycle pulse when a partial frame is discarded by the timeout.
- `err_count`, out, 8: count of timeouts, saturating at 255.

## Operation
- `raw` assembly: byte k of the frame (k = 0 is the first received) lands at `raw[8k+7:8k]`.
- States:
  - IDLE: `byte_idx = 0`. On `byte_valid`, store byte 0 and go to COLLECT. If `FRAME_BYTES` would be 1, that value is illegal and is not supported.
  - COLLECT: on `byte_valid`, store the byte at `byte_idx` and increment `byte_idx`. When the stored byte is byte `FRAME_BYTES-1`:
    - register `frame` from the completed `raw`, after optional reversal;
    - pulse `frame_valid`;
    - return to IDLE.
- Only one IDLE/COLLECT FSM exists; the completion path has no separate DONE state.
- `byte_idx` width is `$clog2(FRAME_BYTES)`. It never wraps past `FRAME_BYTES-1`.
- Timeout counter:
  - cleared on every accepted byte and in IDLE;
  - increments each cycle in COLLECT;
  - on reaching `TIMEOUT_CYCLES-1` with no `byte_valid`: go to IDLE, discard `raw`, pulse `err_timeout`, and increment `err_count` if it is below 255.
- `frame` is never zeroed or altered between completions. A timeout or `clear` leaves it unchanged.
- Partial contents of `raw` are not visible on any output.

## Timing
- Reset values:
  - `frame = 0`, `frame_valid = 0`, `busy = 0`, `err_timeout = 0`, `err_count = 0`;
  - state IDLE, `byte_idx = 0`, timeout counter 0.
- Latency: the last byte's `byte_valid` in cycle N produces `frame` updated and `frame_valid = 1` in cycle N+1 only. In cycle N+1 the block is already in IDLE and can accept byte 0 of the next frame.
- Back-to-back `byte_valid` on consecutive cycles is accepted. There is no backpressure, and every strobe is consumed.
- `byte_valid` in the same cycle as timeout expiry: the byte wins; it is stored and the counter is cleared, with no error.
- `clear` together with `byte_valid`: `clear` wins, the byte is discarded, and the state is IDLE next cycle. No error pulse occurs and `err_count` is unchanged.
- `clear` in the same cycle as the final byte: the frame is not delivered.
- Reset asserted mid-frame: all outputs immediately take their reset values.

## Configuration
- `ARD_FRAME_TIMEOUT_EN` defined: the timeout counter, `err_timeout` and `err_count` logic are present, as described above.
- `ARD_FRAME_TIMEOUT_EN` undefined:
  - no timeout counter is instantiated;
  - COLLECT waits indefinitely, and only `clear` or `reset` abandons a partial frame;
  - `err_timeout` is tied to 0 and `err_count` is tied to 0;
  - the ports remain present.

## Test plan
- Basic frame: `FRAME_BYTES = 10`, `REVERSE = 0`, send bytes 0x01..0x0A on consecutive cycles. Expect `frame = 80'h0A090807060504030201`, with `frame_valid` high for exactly one cycle, in the cycle after 0x0A.
- Reversal: `REVERSE = 1`, `FRAME_BYTES = 2`, send 0x01 then 0x00. Expect `frame = 16'h8000`.
- Timeout: `TIMEOUT_CYCLES` shortened to 50 via `CLKFRQ`/`BAUDRATE`. Send 3 bytes, then idle for 60 cycles. Expect:
  - `err_timeout` pulses once, 50 cycles after the last byte;
  - `err_count = 1`, `busy = 0`;
  - `frame` is unchanged;
  - a following full frame is assembled correctly from its first byte.
- Race: with the timeout armed, `byte_valid` arrives exactly in the expiry cycle. Expect no `err_timeout` and the byte stored at the correct index.
- Clear/abort:
  - `clear` with `byte_valid` on byte 5: expect `busy = 0` next cycle and no `frame_valid`;
  - assert `reset` low mid-frame: all outputs go to 0 asynchronously, before the next clock edge.
- Saturation (macro defined): force 260 timeouts. Expect `err_count` to hold at 255. With the macro undefined, the same stimulus leaves `err_count = 0` and `busy = 1`.
